mem_access_unit: RTL
====================

# mem_access_unit

Load/store initiator sitting between the single-cycle CPU datapath and the 4 KB word-addressed data memory. It accepts byte, halfword and word load/store requests with byte addresses. It issues word-wide accesses to the data memory, which has a combinational read and a synchronous write. It performs sign/zero extension on loads and read-modify-write merging on sub-word stores, and handshakes completion back to the core with a busy/done pair.

## Interface
Parameters:
- ADDR_W, 10, data memory word-address width; `dm_addr` spans byte-address bits [ADDR_W+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  request strobe, sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- sext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  byte address; bits [31:ADDR_W+2] ignored, so addresses wrap.
- wdata  input  32  store data, right-justified for byte/half.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; request rejected.
- rdata  output  32  load result; holds until the next load completes.
- dm_addr  output  ADDR_W  word address to the data memory.
- dm_din  output  32  write data to the data memory.
- dm_we  output  1  write enable to the data memory.
- dm_dout  input  32  combinational read data from the data memory.

## Operation
- FSM states: IDLE, RD, WR.
- IDLE, accept:
  - req=1 latches addr, we, size, sext and wdata.
  - Reserved size, or misaligned access when the trap is compiled in: done<=1, err<=1, stay IDLE. No dm_we is issued.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte/half store: go to RD.
- RD: dm_addr = latched word address.
  - Load: at the clock edge, rdata<=extracted lane, done<=1, go to IDLE.
  - Sub-word store: at the clock edge, capture dm_dout into the merge register, go to WR.
- WR: dm_we=1 combinationally, dm_din = wdata (word store) or the merged word (sub-word store). At the clock edge, done<=1, go to IDLE.
- Lanes are little-endian:
  - Byte n occupies bits [8n+7:8n].
  - The half at addr[1]=1 occupies [31:16].
  - Merging replaces only the addressed lane(s) with wdata[7:0] or wdata[15:0].
- Extension: sext=1 replicates the lane MSB into the upper bits; sext=0 zero-fills them. Word loads ignore sext.
- dm_we is 0 in every state other than WR.
- dm_addr is don't-care in IDLE and is driven from the latched address.
- req while busy=1 is ignored; nothing is queued.
- A new request is accepted in the cycle where done=1, because the FSM is already in IDLE.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, rdata 0, dm_we 0, dm_din 0, dm_addr 0, all latches 0.
- Accept edge = E0. done is high in the cycle following:
  - Error: E0, so latency 1.
  - Load or word store: E1, so latency 2.
  - Sub-word store: E2, so latency 3.
- dm_we is high for exactly one cycle per store: the cycle before done.
- Reset asserted mid-operation: dm_we drops immediately (asynchronous). If reset arrives before the WR edge, no write occurs and memory is unchanged. No done is produced.
- err is cleared on every done pulse that has no error.

## Configuration
- MAU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, returns done+err with latency 1 and no memory access.
- MAU_MISALIGN_TRAP_EN undefined: low address bits are forced to alignment (addr[0] cleared for half, addr[1:0] cleared for word) and the access proceeds normally. err is raised only for size=11.

## Test plan
- Word store, addr=0x10, wdata=0xDEADBEEF -> dm_we high exactly one cycle with dm_addr=4 and dm_din=0xDEADBEEF; done in cycle 2, err=0.
- After the word store, byte load at addr=0x13 -> rdata=0xFFFFFFDE with sext=1, and 0x000000DE with sext=0. Half load at 0x10 with sext=1 -> 0xFFFFBEEF.
- Byte store, addr=0x11, wdata=0x123456AA -> memory word 4 becomes 0xDEADAAEF. dm_we is high only in the WR cycle; done in cycle 3.
- Half store at addr=0x11, wdata=0x5555:
  - MAU_MISALIGN_TRAP_EN defined: done=1, err=1 in cycle 1; word 4 unchanged.
  - Undefined: word 4 becomes 0xDEAD5555; err=0.
  - size=11 in either build: err=1.
- Byte store in progress, rst_n driven low during RD -> busy, done and dm_we are 0 immediately; word 4 unchanged; the FSM resumes in IDLE after release.
- req held high across two load requests -> the second is accepted in the cycle done=1 for the first. Any req pulse seen while busy=1 produces no extra done.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and data-memory bus for mem_access_unit.
// The master modport is the core/memory environment; the slave modport is the unit.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;

    modport master (
        output req, we, size, sext, addr, wdata, dm_dout,
        input  busy, done, err, rdata, dm_addr, dm_din, dm_we
    );

    modport slave (
        input  req, we, size, sext, addr, wdata, dm_dout,
        output busy, done, err, rdata, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte/half/word accesses onto a word-wide memory with RMW sub-word stores.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRd, StWr} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_sext;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merge;
    logic [31:0]         r_rdata;
    logic                r_done;
    logic                r_err;

    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_bad;
    logic [ADDR_W+1:0]   w_addr_in;
    logic [ADDR_W+1:0]   w_addr_al;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;
    logic                w_unused_addr;

    assign w_unused_addr = ^bus.addr[31:ADDR_W+2];
    assign w_addr_in     = bus.addr[ADDR_W+1:0];

    always_comb begin
        w_addr_al = w_addr_in;
`ifdef MAU_MISALIGN_TRAP_EN
        w_bad = (bus.size == 2'b11)
              || ((bus.size == 2'b01) && w_addr_in[0])
              || ((bus.size == 2'b10) && (w_addr_in[1:0] != 2'b00));
`else
        w_bad = (bus.size == 2'b11);
        if (bus.size == 2'b01) w_addr_al[0] = 1'b0;
        if (bus.size == 2'b10) w_addr_al[1:0] = 2'b00;
`endif
    end

    // Lane select and extension on the combinational memory read data.
    always_comb begin
        w_byte = bus.dm_dout[8*r_addr[1:0] +: 8];
        w_half = r_addr[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = bus.dm_dout;
        endcase
    end

    always_comb begin
        w_merge = bus.dm_dout;
        if (r_size == 2'b00) w_merge[8*r_addr[1:0] +: 8] = r_wdata[7:0];
        else                 w_merge[16*r_addr[1] +: 16] = r_wdata[15:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            StIdle: begin
                if (bus.req) begin
                    if (w_bad) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else if (bus.we && (bus.size == 2'b10)) begin
                        w_state_nxt = StWr;
                    end else begin
                        w_state_nxt = StRd;
                    end
                end
            end
            StRd: begin
                if (r_we) begin
                    w_state_nxt = StWr;
                end else begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                end
            end
            StWr: begin
                w_state_nxt = StIdle;
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b0;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if ((r_state == StIdle) && bus.req) begin
                r_we    <= bus.we;
                r_size  <= bus.size;
                r_sext  <= bus.sext;
                r_addr  <= w_addr_al;
                r_wdata <= bus.wdata;
            end
            if ((r_state == StRd) && !r_we) r_rdata <= w_load;
            if ((r_state == StRd) && r_we)  r_merge <= w_merge;
        end
    end

    // Write strobe decodes straight from state so reset kills it without waiting for a clock.
    assign bus.dm_we   = (r_state == StWr);
    assign bus.dm_din  = bus.dm_we ? ((r_size == 2'b10) ? r_wdata : r_merge) : 32'h0;
    assign bus.dm_addr = r_addr[ADDR_W+1:2];
    assign bus.busy    = (r_state != StIdle);
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
endmodule
